// File: rtl/acia_ctrl.sv
// acia_ctrl: drives a 6850-style ACIA. After reset it writes a master reset
// and then the CFG control byte. It then polls the status register. It moves
// received bytes to a valid/ready output and writes bytes from two
// requesters, granted round-robin.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   reinit              one-cycle pulse that restarts the init sequence
//   tx0_*, tx1_*        requester byte/valid inputs, ready pulse outputs
//   rx_data/valid/ready received byte handshake toward the consumer
//   err_cnt             saturating count of receive-error events
//   a_cs/a_we/a_rs      ACIA chip select, write enable, register select
//   a_din, a_dout       ACIA write data, registered read data
//   init_done           high once the CFG write has completed
module acia_ctrl #(
    parameter logic [7:0] CFG = 8'h15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reinit,
    input  logic [7:0] tx0_data,
    input  logic       tx0_valid,
    output logic       tx0_ready,
    input  logic [7:0] tx1_data,
    input  logic       tx1_valid,
    output logic       tx1_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic [7:0] err_cnt,
    output logic       a_cs,
    output logic       a_we,
    output logic       a_rs,
    output logic [7:0] a_din,
    input  logic [7:0] a_dout,
    output logic       init_done
);

    typedef enum logic [2:0] {
        S_RST, S_INIT0, S_INIT1, S_POLL,
        S_STAT, S_RDREQ, S_RDCAP, S_WR
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic       last_gnt;
    logic       prev_err;
    logic [7:0] wr_byte;
    logic       pick1;

    // Requester 1 wins if it is the only one valid.
    // It also wins if both are valid and requester 0 was granted last.
    assign pick1 = tx1_valid && (!tx0_valid || !last_gnt);

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= S_RST;
        else
            state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            S_RST:   state_nx = S_INIT0;
            S_INIT0: state_nx = S_INIT1;
            S_INIT1: state_nx = S_POLL;
            S_POLL:  state_nx = S_STAT;
            S_STAT: begin
                if (a_dout[0] && !rx_valid)
                    state_nx = S_RDREQ;
                else if (a_dout[1] && (tx0_valid || tx1_valid))
                    state_nx = S_WR;
                else
                    state_nx = S_POLL;
            end
            S_RDREQ: state_nx = S_RDCAP;
            S_RDCAP: state_nx = S_POLL;
            S_WR:    state_nx = S_POLL;
        endcase
        if (reinit)
            state_nx = S_INIT0;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt  <= 1'b1;
            wr_byte   <= 8'h00;
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            err_cnt   <= 8'h00;
            prev_err  <= 1'b0;
            init_done <= 1'b0;
        end else begin
            // last_gnt also names the requester served by the coming WR
            if (state == S_STAT && state_nx == S_WR) begin
                last_gnt <= pick1;
                wr_byte  <= pick1 ? tx1_data : tx0_data;
            end
            if (state == S_RDCAP) begin
                rx_data  <= a_dout;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            // Count rising edges of the error bit across status samples
            if (state == S_STAT) begin
                prev_err <= a_dout[4];
                if (a_dout[4] && !prev_err && err_cnt != 8'hFF)
                    err_cnt <= err_cnt + 8'd1;
            end
            if (reinit)
                init_done <= 1'b0;
            else if (state == S_INIT1)
                init_done <= 1'b1;
        end
    end

    // Outputs decoded from the state register
    always_comb begin
        a_cs      = 1'b0;
        a_we      = 1'b0;
        a_rs      = 1'b0;
        a_din     = 8'h00;
        tx0_ready = 1'b0;
        tx1_ready = 1'b0;
        unique case (state)
            S_RST, S_STAT, S_RDCAP: ;
            S_INIT0: begin
                a_cs  = 1'b1;
                a_we  = 1'b1;
                a_din = 8'h03;
            end
            S_INIT1: begin
                a_cs  = 1'b1;
                a_we  = 1'b1;
                a_din = CFG;
            end
            S_POLL: a_cs = 1'b1;
            S_RDREQ: begin
                a_cs = 1'b1;
                a_rs = 1'b1;
            end
            S_WR: begin
                a_cs      = 1'b1;
                a_we      = 1'b1;
                a_rs      = 1'b1;
                a_din     = wr_byte;
                tx0_ready = !last_gnt;
                tx1_ready = last_gnt;
            end
        endcase
    end

endmodule

// File: tb/tb_acia_ctrl.sv
// tb_acia_ctrl: scoreboard bench for acia_ctrl with a small ACIA model.
// Expected writes and grants are queued by stimulus and popped by a monitor.
module tb_acia_ctrl;

    localparam logic [7:0] CFG = 8'h15;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       reinit = 1'b0;
    logic [7:0] tx0_data = 8'h00;
    logic       tx0_valid = 1'b0;
    logic       tx0_ready;
    logic [7:0] tx1_data = 8'h00;
    logic       tx1_valid = 1'b0;
    logic       tx1_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic [7:0] err_cnt;
    logic       a_cs;
    logic       a_we;
    logic       a_rs;
    logic [7:0] a_din;
    logic [7:0] a_dout = 8'h00;
    logic       init_done;

    acia_ctrl #(.CFG(CFG)) dut (
        .clk(clk), .rst(rst), .reinit(reinit),
        .tx0_data(tx0_data), .tx0_valid(tx0_valid), .tx0_ready(tx0_ready),
        .tx1_data(tx1_data), .tx1_valid(tx1_valid), .tx1_ready(tx1_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .err_cnt(err_cnt),
        .a_cs(a_cs), .a_we(a_we), .a_rs(a_rs),
        .a_din(a_din), .a_dout(a_dout),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [8:0] exp_wr[$];
    int         exp_rdy[$];
    int         rd_cnt = 0;
    int         wr_cnt = 0;
    logic [8:0] mon_e;
    int         mon_g;

    logic [7:0] stat_base = 8'h00;
    logic [7:0] rx_byte = 8'h00;
    int         tog_left = 0;
    bit         phase = 1'b0;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    bit         got0 = 1'b0;
    bit         got1 = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ACIA model: registered read data; optional bit-4 toggling per status read
    always @(posedge clk) begin
        if (a_cs && !a_we) begin
            if (a_rs) begin
                a_dout <= rx_byte;
            end else if (tog_left > 0 && !phase) begin
                a_dout <= stat_base | 8'h10;
                phase = 1'b1;
                tog_left--;
            end else begin
                a_dout <= stat_base;
                phase = 1'b0;
            end
        end
    end

    // Monitor: compares every ACIA write and every ready pulse
    always @(negedge clk) begin
        if (!rst) begin
            if (a_cs && a_we) begin
                wr_cnt++;
                if (exp_wr.size() == 0) begin
                    chk("unexpected_write", {23'd0, a_rs, a_din}, 32'h1FF);
                end else begin
                    mon_e = exp_wr.pop_front();
                    chk("write", {23'd0, a_rs, a_din}, {23'd0, mon_e});
                end
            end
            if (a_cs && !a_we && a_rs)
                rd_cnt++;
            if (tx0_ready || tx1_ready) begin
                mon_g = tx1_ready ? (tx0_ready ? 2 : 1) : 0;
                if (exp_rdy.size() == 0)
                    chk("unexpected_grant", mon_g, 9);
                else
                    chk("grant", mon_g, exp_rdy.pop_front());
            end
        end
    end

    // Requesters: hold valid/data until ready, then move to next byte
    always @(negedge clk) begin
        if (tx0_ready) got0 = 1'b1;
        if (tx1_ready) got1 = 1'b1;
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (got0) begin
            got0 = 1'b0;
            if (q0.size() != 0) void'(q0.pop_front());
        end
        if (got1) begin
            got1 = 1'b0;
            if (q1.size() != 0) void'(q1.pop_front());
        end
        tx0_valid = (q0.size() != 0);
        tx0_data  = tx0_valid ? q0[0] : 8'h00;
        tx1_valid = (q1.size() != 0);
        tx1_data  = tx1_valid ? q1[0] : 8'h00;
    end

    task automatic wait_drain(string name, int bound);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0 || exp_rdy.size() != 0 ||
                exp_wr.size() != 0) && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk(name, n < bound, 1);
    endtask

    initial begin
        int n;
        int r0;
        int w0;
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cs", a_cs, 0);
        chk("rst_init_done", init_done, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ready", {tx1_ready, tx0_ready}, 0);

        // Init sequence: 03 then CFG, back to back, then status polls
        exp_wr.push_back({1'b0, 8'h03});
        exp_wr.push_back({1'b0, CFG});
        @(posedge clk);
        #1 rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(a_cs && a_we) && n < 10);
        chk("init_start", n < 10, 1);
        @(negedge clk);
        chk("init_consec", {a_cs, a_we}, 2'b11);
        @(negedge clk);
        chk("init_done", init_done, 1);
        chk("first_poll", {a_cs, a_we, a_rs}, 3'b100);
        chk("init_writes", exp_wr.size(), 0);

        // Round robin with both requesters held valid
        stat_base = 8'h02;
        exp_wr.push_back({1'b1, 8'h10});
        exp_wr.push_back({1'b1, 8'h20});
        exp_wr.push_back({1'b1, 8'h11});
        exp_wr.push_back({1'b1, 8'h21});
        exp_rdy.push_back(0);
        exp_rdy.push_back(1);
        exp_rdy.push_back(0);
        exp_rdy.push_back(1);
        q0.push_back(8'h10);
        q0.push_back(8'h11);
        q1.push_back(8'h20);
        q1.push_back(8'h21);
        wait_drain("rr_drain", 200);

        // Single requester write
        exp_wr.push_back({1'b1, 8'hA5});
        exp_rdy.push_back(0);
        q0.push_back(8'hA5);
        wait_drain("single_drain", 100);

        // Error-bit edges: 5 rises, then constant 1, then 300 rises
        stat_base = 8'h00;
        repeat (4) @(negedge clk);
        tog_left = 5;
        n = 0;
        while (tog_left > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        chk("err_5", err_cnt, 5);
        stat_base = 8'h10;
        repeat (40) @(negedge clk);
        chk("err_const", err_cnt, 6);
        stat_base = 8'h00;
        repeat (10) @(negedge clk);
        tog_left = 300;
        n = 0;
        while (tog_left > 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("err_toggle_time", n < 3000, 1);
        repeat (10) @(negedge clk);
        chk("err_sat", err_cnt, 8'hFF);

        // RX before TX, then backpressure
        w0 = wr_cnt;
        rx_byte = 8'h5C;
        stat_base = 8'h03;
        exp_wr.push_back({1'b1, 8'h77});
        exp_rdy.push_back(0);
        q0.push_back(8'h77);
        n = 0;
        while (!rx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rx_time", n < 50, 1);
        chk("rx_data", rx_data, 8'h5C);
        chk("rx_before_tx", wr_cnt - w0, 0);
        r0 = rd_cnt;
        rx_byte = 8'h99;
        repeat (30) @(negedge clk);
        chk("rx_backpressure", rd_cnt - r0, 0);
        chk("rx_held_valid", rx_valid, 1);
        chk("rx_held_data", rx_data, 8'h5C);
        chk("tx_after_rx", exp_wr.size(), 0);

        // reinit during a status poll
        exp_wr.push_back({1'b0, 8'h03});
        exp_wr.push_back({1'b0, CFG});
        n = 0;
        while (!(a_cs && !a_we && !a_rs) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("poll_found", n < 10, 1);
        reinit = 1'b1;
        @(posedge clk);
        #1 reinit = 1'b0;
        @(negedge clk);
        chk("reinit_clear", init_done, 0);
        repeat (6) @(negedge clk);
        chk("reinit_writes", exp_wr.size(), 0);
        chk("reinit_done", init_done, 1);
        chk("reinit_err", err_cnt, 8'hFF);
        chk("reinit_rx_valid", rx_valid, 1);
        chk("reinit_rx_data", rx_data, 8'h5C);

        // Consumer accepts the byte
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        chk("rx_consumed", rx_valid, 0);
        stat_base = 8'h00;
        repeat (12) @(negedge clk);
        chk("rx_next", rx_data, 8'h99);
        chk("end_rdy", exp_rdy.size(), 0);
        chk("end_wr", exp_wr.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
